// File: rtl/banked_sram_mem.sv
// Banked word memory built from 32x256 macros with one write port and one read port.
// Supports byte-masked writes, a credited read-response buffer, write-to-read bypass and an optional zero-fill sweep.
module banked_sram_mem #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 10,
    parameter int MEM_SIZE  = 1 << ADDR_W,
    parameter int WR_BYPASS = 1,
    parameter int INIT_ZERO = 0,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_vld_i,
    output logic              wr_rdy_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [DATA_W/8-1:0] wr_be_i,
    output logic              wr_err_o,
    input  logic              rd_vld_i,
    output logic              rd_rdy_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_rsp_vld_o,
    input  logic              rd_rsp_rdy_i,
    output logic [DATA_W-1:0] rd_rsp_data_o,
    output logic              rd_rsp_err_o
);

    localparam int NUM_COLS  = (DATA_W + 31) / 32;
    localparam int PAD_W     = NUM_COLS * 32;
    localparam int PAD_BE    = NUM_COLS * 4;
    localparam int NUM_BANKS = (MEM_SIZE + 255) / 256;
    localparam int PTR_W     = $clog2(RSP_DEPTH);
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W + 1)'(MEM_SIZE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

    // ------------------------------------------------------------------
    // Control FSM: optional zero-fill sweep, then normal operation
    // ------------------------------------------------------------------
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_init_addr;
    logic [ADDR_W-1:0] w_init_addr_next;
    logic              w_init_we;
    logic              w_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            r_init_addr <= '0;
        end else begin
            r_state     <= w_state_next;
            r_init_addr <= w_init_addr_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_init_addr_next = r_init_addr;
        w_init_we        = 1'b0;
        w_run            = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_we        = !rst;
                w_init_addr_next = r_init_addr + ADDR_W'(1);
                if (r_init_addr == LAST_ADDR) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_run = !rst;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic w_wr_in_range;
    logic w_rd_in_range;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_byp_hit;

    assign w_wr_in_range = ({1'b0, wr_addr_i} < MEM_LIMIT);
    assign w_rd_in_range = ({1'b0, rd_addr_i} < MEM_LIMIT);
    assign w_wr_acc      = wr_vld_i & w_run;
    assign w_rd_acc      = rd_vld_i & rd_rdy_o;
    assign w_byp_hit     = (WR_BYPASS != 0) & w_wr_acc & w_wr_in_range &
                           w_rd_acc & w_rd_in_range & (wr_addr_i == rd_addr_i);

    // Write port is shared between the sweep and user writes; the sweep never overlaps RUN.
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [PAD_W-1:0]  w_mem_wdata;
    logic [PAD_BE-1:0] w_mem_wbe;

    assign w_mem_we    = w_init_we | (w_wr_acc & w_wr_in_range);
    assign w_mem_waddr = w_init_we ? r_init_addr : wr_addr_i;
    assign w_mem_wdata = w_init_we ? '0 : PAD_W'(wr_data_i);
    assign w_mem_wbe   = w_init_we ? '1 : PAD_BE'(wr_be_i);

    // ------------------------------------------------------------------
    // Macro tiles: NUM_BANKS rows of NUM_COLS 32-bit columns
    // ------------------------------------------------------------------
    logic [NUM_BANKS-1:0] w_wr_cs;
    logic [NUM_BANKS-1:0] w_rd_cs;
    logic [31:0]          w_col_dout [NUM_BANKS][NUM_COLS];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            assign w_wr_cs[gi] = w_mem_we & ((w_mem_waddr >> 8) == ADDR_W'(gi));
            assign w_rd_cs[gi] = w_rd_acc & w_rd_in_range & ((rd_addr_i >> 8) == ADDR_W'(gi));

            for (gj = 0; gj < NUM_COLS; gj++) begin : g_col
                logic [31:0] r_mem [0:255];
                logic [31:0] r_dout;

                // Read-during-write on the macro returns the old word; bypass is merged later.
                always_ff @(posedge clk) begin
                    if (w_wr_cs[gi]) begin
                        for (int k = 0; k < 4; k++) begin
                            if (w_mem_wbe[gj*4 + k]) begin
                                r_mem[w_mem_waddr[7:0]][k*8 +: 8] <= w_mem_wdata[gj*32 + k*8 +: 8];
                            end
                        end
                    end
                    if (w_rd_cs[gi]) begin
                        r_dout <= r_mem[rd_addr_i[7:0]];
                    end
                end

                assign w_col_dout[gi][gj] = r_dout;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read pipeline stage between acceptance and buffer capture
    // ------------------------------------------------------------------
    logic                 r_rd_pend;
    logic                 r_rd_err;
    logic [NUM_BANKS-1:0] r_rd_sel;
    logic                 r_byp_en;
    logic [PAD_W-1:0]     r_byp_data;
    logic [PAD_BE-1:0]    r_byp_be;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_acc;
        end
        r_rd_err   <= !w_rd_in_range;
        r_rd_sel   <= w_rd_cs;
        r_byp_en   <= w_byp_hit;
        r_byp_data <= PAD_W'(wr_data_i);
        r_byp_be   <= PAD_BE'(wr_be_i);
    end

    logic [PAD_W-1:0] w_macro_dout;
    logic [PAD_W-1:0] w_merged;

    always_comb begin
        w_macro_dout = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (r_rd_sel[b]) begin
                    w_macro_dout[c*32 +: 32] = w_macro_dout[c*32 +: 32] | w_col_dout[b][c];
                end
            end
        end
        w_merged = w_macro_dout;
        for (int k = 0; k < PAD_BE; k++) begin
            if (r_byp_en && r_byp_be[k]) begin
                w_merged[k*8 +: 8] = r_byp_data[k*8 +: 8];
            end
        end
        if (r_rd_err) begin
            w_merged = '0;
        end
    end

    // ------------------------------------------------------------------
    // Response buffer with credit accounting
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]    r_fifo_data [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] r_fifo_err;
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_wr_err;
    logic                 w_pop;
    logic [CNT_W:0]       w_credits_used;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop = (r_count != '0) & rd_rsp_rdy_i;

    // An entry leaving this cycle frees its credit immediately so an unstalled stream runs at one read per cycle.
    assign w_credits_used = (CNT_W + 1)'(r_count) + (CNT_W + 1)'(r_rd_pend) - (CNT_W + 1)'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_wr_err <= 1'b0;
        end else begin
            if (r_rd_pend) begin
                r_fifo_err[r_wptr] <= r_rd_err;
                r_wptr             <= next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            r_count  <= r_count + CNT_W'(r_rd_pend) - CNT_W'(w_pop);
            r_wr_err <= w_wr_acc & !w_wr_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (r_rd_pend) begin
            r_fifo_data[r_wptr] <= w_merged[DATA_W-1:0];
        end
    end

    assign wr_rdy_o      = w_run;
    assign wr_err_o      = r_wr_err;
    assign rd_rdy_o      = w_run & (w_credits_used < (CNT_W + 1)'(RSP_DEPTH));
    assign rd_rsp_vld_o  = (r_count != '0);
    assign rd_rsp_data_o = rd_rsp_vld_o ? r_fifo_data[r_rptr] : '0;
    assign rd_rsp_err_o  = rd_rsp_vld_o & r_fifo_err[r_rptr];

endmodule

// File: tb/tb_banked_sram_mem.sv
// Bench for banked_sram_mem: two instances (bypass on/off) driven identically and checked
// every cycle against a queue/array model, plus directed literal expectations.
module tb_banked_sram_mem;

    localparam int DW    = 64;
    localparam int AW    = 10;
    localparam int MS    = 512;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_vld = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [7:0]    wr_be = '0;
    logic          rd_vld = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rsp_rdy = 1'b1;

    logic          wr_rdy_a, wr_err_a, rd_rdy_a, rsp_vld_a, rsp_err_a;
    logic [DW-1:0] rsp_data_a;
    logic          wr_rdy_b, wr_err_b, rd_rdy_b, rsp_vld_b, rsp_err_b;
    logic [DW-1:0] rsp_data_b;

    always #5 clk = ~clk;

    banked_sram_mem #(.DATA_W(DW), .ADDR_W(AW), .MEM_SIZE(MS), .WR_BYPASS(1),
                      .INIT_ZERO(1), .RSP_DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst(rst),
        .wr_vld_i(wr_vld), .wr_rdy_o(wr_rdy_a), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be), .wr_err_o(wr_err_a),
        .rd_vld_i(rd_vld), .rd_rdy_o(rd_rdy_a), .rd_addr_i(rd_addr),
        .rd_rsp_vld_o(rsp_vld_a), .rd_rsp_rdy_i(rsp_rdy),
        .rd_rsp_data_o(rsp_data_a), .rd_rsp_err_o(rsp_err_a)
    );

    banked_sram_mem #(.DATA_W(DW), .ADDR_W(AW), .MEM_SIZE(MS), .WR_BYPASS(0),
                      .INIT_ZERO(1), .RSP_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(rst),
        .wr_vld_i(wr_vld), .wr_rdy_o(wr_rdy_b), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be), .wr_err_o(wr_err_b),
        .rd_vld_i(rd_vld), .rd_rdy_o(rd_rdy_b), .rd_addr_i(rd_addr),
        .rd_rsp_vld_o(rsp_vld_b), .rd_rsp_rdy_i(rsp_rdy),
        .rd_rsp_data_o(rsp_data_b), .rd_rsp_err_o(rsp_err_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = o;
        for (int k = 0; k < 8; k++) begin
            if (be[k]) r[k*8 +: 8] = n[k*8 +: 8];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: word array plus ordered queue of outstanding reads
    // ------------------------------------------------------------------
    typedef struct {
        logic [63:0] da;
        logic [63:0] db;
        logic        err;
        bit          ready;
    } rsp_t;

    rsp_t        q[$];
    logic [63:0] mem [MS];
    int          init_cnt = 0;
    logic        exp_wr_err = 1'b0;
    bit          mvalid = 1'b0;

    always @(negedge clk) begin : model
        bit          run, hv, pop, erdy, wacc, racc;
        rsp_t        e;
        logic [63:0] old;
        run  = (init_cnt == 0) && !rst;
        hv   = (q.size() > 0) && q[0].ready;
        pop  = hv && rsp_rdy;
        erdy = run && ((q.size() - (pop ? 1 : 0)) < DEPTH);
        if (mvalid) begin
            chk("wr_rdy_a", wr_rdy_a, run);
            chk("wr_rdy_b", wr_rdy_b, run);
            chk("rd_rdy_a", rd_rdy_a, erdy);
            chk("rd_rdy_b", rd_rdy_b, erdy);
            chk("rsp_vld_a", rsp_vld_a, hv);
            chk("rsp_vld_b", rsp_vld_b, hv);
            chk("wr_err_a", wr_err_a, exp_wr_err);
            chk("wr_err_b", wr_err_b, exp_wr_err);
            if (hv) begin
                chk("rsp_data_a", rsp_data_a, q[0].da);
                chk("rsp_data_b", rsp_data_b, q[0].db);
                chk("rsp_err_a", rsp_err_a, q[0].err);
                chk("rsp_err_b", rsp_err_b, q[0].err);
            end
        end
        if (rst) begin
            init_cnt   = MS;
            q.delete();
            foreach (mem[i]) mem[i] = '0;
            exp_wr_err = 1'b0;
            mvalid     = 1'b1;
        end else if (mvalid) begin
            if (pop) void'(q.pop_front());
            foreach (q[i]) q[i].ready = 1'b1;
            wacc = wr_vld && run;
            racc = rd_vld && erdy;
            if (racc) begin
                if (int'(rd_addr) < MS) begin
                    old  = mem[int'(rd_addr)];
                    e.db = old;
                    e.da = (wacc && wr_addr == rd_addr) ? merge(old, wr_data, wr_be) : old;
                    e.err = 1'b0;
                end else begin
                    e.da  = '0;
                    e.db  = '0;
                    e.err = 1'b1;
                end
                e.ready = 1'b0;
                q.push_back(e);
            end
            if (wacc && int'(wr_addr) < MS) begin
                mem[int'(wr_addr)] = merge(mem[int'(wr_addr)], wr_data, wr_be);
            end
            exp_wr_err = wacc && (int'(wr_addr) >= MS);
            if (init_cnt > 0) init_cnt--;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] be);
        wr_vld  = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        tick();
        wr_vld  = 1'b0;
        $display("wr   addr=%h data=%h be=%h", a, d, be);
    endtask

    task automatic issue_read(input logic [AW-1:0] a);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        rd_vld  = 1'b1;
        rd_addr = a;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = rd_rdy_a;
            tick();
            n++;
        end
        rd_vld = 1'b0;
        chk("rd_accept", acc, 1'b1);
    endtask

    task automatic wait_rsp(input string name, input logic [63:0] ea, input logic [63:0] eb,
                            input logic ee);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (n < 40) begin
            @(negedge clk);
            if (rsp_vld_a) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        chk({name, "_seen"}, seen, 1'b1);
        if (seen) begin
            chk({name, "_data_a"}, rsp_data_a, ea);
            chk({name, "_data_b"}, rsp_data_b, eb);
            chk({name, "_err"}, rsp_err_a, ee);
            $display("rsp  %s a=%h b=%h err=%0b", name, rsp_data_a, rsp_data_b, rsp_err_a);
        end
        tick();
    endtask

    task automatic wait_init(input string name);
        int cnt;
        cnt = 0;
        while (cnt < 2000) begin
            @(negedge clk);
            if (rd_rdy_a) break;
            cnt++;
        end
        chk(name, cnt, MS);
        $display("init %s lasted %0d cycles", name, cnt);
        tick();
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'(i + 1) * 64'h0101_0101_0101_0101;
    endfunction

    initial begin
        int issued, got;
        bit dropped;
        int sel;

        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("reset_vld", rsp_vld_a, 1'b0);
        chk("reset_data", rsp_data_a, 64'h0);
        chk("reset_wr_rdy", wr_rdy_a, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        wait_init("init_len");

        issue_read(AW'(300));
        wait_rsp("init_zero", 64'h0, 64'h0, 1'b0);

        // Byte-masked overwrite in bank 1
        do_write(AW'(12'h105), 64'h1122334455667788, 8'hFF);
        tick();
        do_write(AW'(12'h105), 64'hAAAAAAAA_BBBBBBBB, 8'h0F);
        issue_read(AW'(12'h105));
        wait_rsp("be_merge", 64'h11223344BBBBBBBB, 64'h11223344BBBBBBBB, 1'b0);

        // Same-cycle write and read of the same word
        wr_vld  = 1'b1;
        wr_addr = AW'(7);
        wr_data = '1;
        wr_be   = 8'hF0;
        rd_vld  = 1'b1;
        rd_addr = AW'(7);
        tick();
        wr_vld = 1'b0;
        rd_vld = 1'b0;
        $display("wr+rd addr=007 data=%h be=f0", 64'hFFFFFFFFFFFFFFFF);
        wait_rsp("bypass", 64'hFFFFFFFF00000000, 64'h0, 1'b0);

        // Back-to-back reads under a consumer stall
        for (int i = 0; i < 10; i++) do_write(AW'(i), pat(i), 8'hFF);
        issued  = 0;
        got     = 0;
        dropped = 1'b0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            rsp_rdy = !(c >= 3 && c <= 8);
            rd_vld  = (issued < 10);
            rd_addr = AW'(issued);
            @(negedge clk);
            if (rd_vld && rd_rdy_a) issued++;
            else if (rd_vld) dropped = 1'b1;
            if (rsp_vld_a && rsp_rdy) begin
                chk("stall_order", rsp_data_a, pat(got));
                $display("rsp  stall #%0d data=%h", got, rsp_data_a);
                got++;
            end
            tick();
        end
        rd_vld  = 1'b0;
        rsp_rdy = 1'b1;
        chk("stall_count", got, 10);
        chk("stall_rdy_drop", dropped, 1'b1);

        // Out-of-range accesses
        issue_read(AW'(600));
        wait_rsp("oor_read", 64'h0, 64'h0, 1'b1);
        do_write(AW'(600), '1, 8'hFF);
        @(negedge clk);
        chk("oor_wr_err", wr_err_a, 1'b1);
        tick();
        issue_read(AW'(88));
        wait_rsp("oor_alias88", 64'h0, 64'h0, 1'b0);
        issue_read(AW'(344));
        wait_rsp("oor_alias344", 64'h0, 64'h0, 1'b0);

        // Reset with two responses pending
        rsp_rdy = 1'b0;
        rd_vld  = 1'b1;
        rd_addr = AW'(1);
        tick();
        rd_addr = AW'(2);
        tick();
        rd_vld = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("pending_vld", rsp_vld_a, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_drop_vld", rsp_vld_a, 1'b0);
        chk("rst_drop_data", rsp_data_a, 64'h0);
        tick();
        rst     = 1'b0;
        rsp_rdy = 1'b1;
        wait_init("reinit_len");

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            wr_vld  = ($urandom % 3) != 0;
            sel     = int'($urandom % 4);
            wr_addr = (sel == 0) ? AW'($urandom_range(480, 700)) :
                      (sel == 1) ? AW'($urandom % 8) : AW'($urandom);
            wr_data = {$urandom, $urandom};
            wr_be   = 8'($urandom);
            rd_vld  = ($urandom % 3) != 0;
            sel     = int'($urandom % 4);
            rd_addr = (sel == 0) ? AW'($urandom_range(480, 700)) :
                      (sel == 1) ? AW'($urandom % 8) : AW'($urandom);
            if (($urandom % 4) == 0) rd_addr = wr_addr;
            rsp_rdy = ($urandom % 10) < 7;
            tick();
        end
        wr_vld  = 1'b0;
        rd_vld  = 1'b0;
        rsp_rdy = 1'b1;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
